// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM arbiter: FSM states, grant encoding,
// the fixed lane count and the all-zero strobe pattern that marks a read.
package bootram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACK
    } state_e;

    typedef enum logic {
        GNT_CPU,
        GNT_LDR
    } grant_e;

    localparam int        LANES   = 4;
    localparam logic [3:0] RD_STRB = 4'b0000;

endpackage

// File: rtl/bootram_rr_arb.sv
// Two-requester round-robin arbiter for the boot RAM (bit 0 = CPU, bit 1 = loader).
// The pointer holds the port that wins the next contended cycle and moves only on a grant.
module bootram_rr_arb
    import bootram_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       ena_i,
    output grant_e     gnt_o
);

    grant_e ptr_q;
    grant_e ptr_d;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        gnt_o = ptr_q;
        if (req_i == 2'b01) begin
            gnt_o = GNT_CPU;
        end else if (req_i == 2'b10) begin
            gnt_o = GNT_LDR;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ena_i && (req_i != 2'b00)) begin
            ptr_d = (gnt_o == GNT_CPU) ? GNT_LDR : GNT_CPU;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= GNT_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bootram_arbiter.sv
// Boot RAM arbiter: shares four 2Kx8 byte-lane RAMs between the CPU and loader ports,
// one access per IDLE/ISSUE/ACK pass. Optional write protection with `BOOTRAM_WP_EN.
module bootram_arbiter #(
    parameter int AW    = 11,
    parameter int LANES = bootram_pkg::LANES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_valid,
    input  logic [AW-1:0] cpu_addr,
    input  logic [3:0]    cpu_wstrb,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ready,
    output logic [31:0]   cpu_rdata,
    input  logic          ldr_valid,
    input  logic [AW-1:0] ldr_addr,
    input  logic [3:0]    ldr_wstrb,
    input  logic [31:0]   ldr_wdata,
    output logic          ldr_ready,
    output logic [31:0]   ldr_rdata,
`ifdef BOOTRAM_WP_EN
    input  logic          wp_lock,
    output logic          wp_err,
`endif
    output logic          ram_ce,
    output logic          ram_oce,
    output logic [3:0]    ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    import bootram_pkg::*;

    if (LANES != 4) begin : g_lanes_chk
        $error("bootram_arbiter: LANES must be 4");
    end

    state_e        state_q, state_d;
    grant_e        gnt_q, gnt_d;
    grant_e        arb_gnt;
    logic          rd_q, rd_d;
    logic          ce_q, ce_d;
    logic [3:0]    wre_q, wre_d;
    logic [AW-1:0] ad_q, ad_d;
    logic [31:0]   din_q, din_d;
    logic          cpu_ready_q, cpu_ready_d;
    logic          ldr_ready_q, ldr_ready_d;
`ifdef BOOTRAM_WP_EN
    logic          wp_err_q, wp_err_d;
`endif

    logic [AW-1:0] sel_addr;
    logic [3:0]    sel_strb;
    logic [31:0]   sel_data;

    bootram_rr_arb u_rr_arb (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   ({ldr_valid, cpu_valid}),
        .ena_i   (state_q == ST_IDLE),
        .gnt_o   (arb_gnt)
    );

    assign sel_addr = (arb_gnt == GNT_LDR) ? ldr_addr  : cpu_addr;
    assign sel_strb = (arb_gnt == GNT_LDR) ? ldr_wstrb : cpu_wstrb;
    assign sel_data = (arb_gnt == GNT_LDR) ? ldr_wdata : cpu_wdata;

    // Lane controls are computed one state ahead so every RAM-side output leaves a flop.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rd_d        = rd_q;
        ad_d        = ad_q;
        din_d       = din_q;
        ce_d        = 1'b0;
        wre_d       = RD_STRB;
        cpu_ready_d = 1'b0;
        ldr_ready_d = 1'b0;
`ifdef BOOTRAM_WP_EN
        wp_err_d    = wp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid || ldr_valid) begin
                    state_d = ST_ISSUE;
                    gnt_d   = arb_gnt;
                    rd_d    = (sel_strb == RD_STRB);
                    ad_d    = sel_addr;
                    din_d   = sel_data;
                    ce_d    = 1'b1;
                    wre_d   = sel_strb;
`ifdef BOOTRAM_WP_EN
                    if ((arb_gnt == GNT_CPU) && wp_lock && (sel_strb != RD_STRB)) begin
                        wre_d    = RD_STRB;
                        wp_err_d = 1'b1;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                state_d     = ST_ACK;
                cpu_ready_d = (gnt_q == GNT_CPU);
                ldr_ready_d = (gnt_q == GNT_LDR);
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_CPU;
            rd_q        <= 1'b0;
            ce_q        <= 1'b0;
            wre_q       <= RD_STRB;
            ad_q        <= '0;
            din_q       <= '0;
            cpu_ready_q <= 1'b0;
            ldr_ready_q <= 1'b0;
`ifdef BOOTRAM_WP_EN
            wp_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rd_q        <= rd_d;
            ce_q        <= ce_d;
            wre_q       <= wre_d;
            ad_q        <= ad_d;
            din_q       <= din_d;
            cpu_ready_q <= cpu_ready_d;
            ldr_ready_q <= ldr_ready_d;
`ifdef BOOTRAM_WP_EN
            wp_err_q    <= wp_err_d;
`endif
        end
    end

    assign ram_ce    = ce_q;
    assign ram_oce   = ce_q;
    assign ram_wre   = wre_q;
    assign ram_ad    = ad_q;
    assign ram_din   = din_q;
    assign cpu_ready = cpu_ready_q;
    assign ldr_ready = ldr_ready_q;

    // Bypass-mode RAM data is valid during ACK, which is exactly when ready is high.
    assign cpu_rdata = (cpu_ready_q && rd_q) ? ram_dout : 32'h0;
    assign ldr_rdata = (ldr_ready_q && rd_q) ? ram_dout : 32'h0;

`ifdef BOOTRAM_WP_EN
    assign wp_err = wp_err_q;
`endif

endmodule

// File: tb/tb_bootram_arbiter.sv
// Directed scoreboard bench for bootram_arbiter with a behavioural four-lane RAM model.
// Define BOOTRAM_WP_EN to also exercise the write-protect path.
module tb_bootram_arbiter;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, ldr_valid;
    logic [10:0] cpu_addr, ldr_addr;
    logic [3:0]  cpu_wstrb, ldr_wstrb;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_ready, ldr_ready;
    logic [31:0] cpu_rdata, ldr_rdata;
    logic        ram_ce, ram_oce;
    logic [3:0]  ram_wre;
    logic [10:0] ram_ad;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
`ifdef BOOTRAM_WP_EN
    logic        wp_lock;
    logic        wp_err;
`endif

    logic [31:0] ramMem [2048];
    logic [31:0] refMem [2048];
    exp_t        sbQ [$];
    int          checks = 0;
    int          errors = 0;
    bit          rrNext = 1'b0;
    bit          wpLock = 1'b0;
    logic [10:0] cAddr, lAddr;
    logic [3:0]  cStrb, lStrb;
    logic [31:0] cData, lData;

    always #5 clk = ~clk;

    bootram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wstrb (cpu_wstrb),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .ldr_valid (ldr_valid),
        .ldr_addr  (ldr_addr),
        .ldr_wstrb (ldr_wstrb),
        .ldr_wdata (ldr_wdata),
        .ldr_ready (ldr_ready),
        .ldr_rdata (ldr_rdata),
`ifdef BOOTRAM_WP_EN
        .wp_lock   (wp_lock),
        .wp_err    (wp_err),
`endif
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_wre   (ram_wre),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

`ifdef BOOTRAM_WP_EN
    assign wp_lock = wpLock;
`endif

    // Four byte-lane RAMs in bypass mode: read data appears the cycle after CE.
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_dout <= ramMem[ram_ad];
            for (int i = 0; i < 4; i++) begin
                if (ram_wre[i]) ramMem[ram_ad][8*i +: 8] <= ram_din[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setCpu(input logic [10:0] a, input logic [3:0] s, input logic [31:0] d);
        cAddr = a; cStrb = s; cData = d;
    endtask

    task automatic setLdr(input logic [10:0] a, input logic [3:0] s, input logic [31:0] d);
        lAddr = a; lStrb = s; lData = d;
    endtask

    task automatic pushExpect(input bit w, input logic [10:0] a, input logic [3:0] s,
                              input logic [31:0] d);
        exp_t e;
        e.port  = w;
        e.rdata = (s == 4'b0000) ? refMem[a] : 32'h0;
        if ((s != 4'b0000) && !(!w && wpLock)) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) refMem[a][8*i +: 8] = d[8*i +: 8];
            end
        end
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        int   n;
        n = 1;
        while (!(cpu_ready || ldr_ready) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        e.port  = 1'b0;
        e.rdata = 32'h0;
        if (sbQ.size() > 0) e = sbQ.pop_front();
        chk({tag, "_ready"}, {30'h0, ldr_ready, cpu_ready}, e.port ? 32'h2 : 32'h1);
        chk({tag, "_cpu_rdata"}, cpu_rdata, e.port ? 32'h0 : e.rdata);
        chk({tag, "_ldr_rdata"}, ldr_rdata, e.port ? e.rdata : 32'h0);
        chk({tag, "_ack_ce"}, {27'h0, ram_wre, ram_ce}, 32'h0);
    endtask

    task automatic applyStimulus(input bit cReq, input bit lReq, input string tag);
        bit          w;
        logic [10:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [3:0]  expWre;
        w      = (cReq && lReq) ? rrNext : lReq;
        a      = w ? lAddr : cAddr;
        s      = w ? lStrb : cStrb;
        d      = w ? lData : cData;
        expWre = (!w && wpLock) ? 4'h0 : s;
        pushExpect(w, a, s, d);
        rrNext = !w;
        cpu_valid = cReq; cpu_addr = cAddr; cpu_wstrb = cStrb; cpu_wdata = cData;
        ldr_valid = lReq; ldr_addr = lAddr; ldr_wstrb = lStrb; ldr_wdata = lData;
        @(negedge clk);
        chk({tag, "_ce"}, {30'h0, ram_oce, ram_ce}, 32'h3);
        chk({tag, "_ad"}, ram_ad, a);
        chk({tag, "_wre"}, ram_wre, expWre);
        chk({tag, "_din"}, ram_din, d);
        checkOutput(tag);
        cpu_valid = 1'b0;
        ldr_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wstrb = '0; cpu_wdata = '0;
        ldr_valid = 1'b0; ldr_addr = '0; ldr_wstrb = '0; ldr_wdata = '0;
        setCpu(0, 0, 0);
        setLdr(0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {27'h0, ram_wre, ram_ce}, 32'h0);
        chk("rst_ready", {30'h0, ldr_ready, cpu_ready}, 32'h0);
        chk("rst_ad", ram_ad, 32'h0);
        chk("rst_din", ram_din, 32'h0);
`ifdef BOOTRAM_WP_EN
        chk("rst_wp_err", wp_err, 32'h0);
`endif
        reset = 1'b0;
        @(negedge clk);

        setCpu(11'h010, 4'hF, 32'hDEADBEEF); applyStimulus(1, 0, "t1_wr");
        setCpu(11'h010, 4'h0, 32'h0);        applyStimulus(1, 0, "t1_rd");

        setCpu(11'h7FF, 4'hF, 32'h11223344); applyStimulus(1, 0, "t2_wr");
        setCpu(11'h7FF, 4'b0100, 32'h00AA0000); applyStimulus(1, 0, "t2_part");
        setCpu(11'h7FF, 4'h0, 32'h0);        applyStimulus(1, 0, "t2_rd");
        chk("t2_refval", refMem[11'h7FF], 32'h11AA3344);

        setLdr(11'h100, 4'hF, 32'hA5A50001); applyStimulus(0, 1, "t3_pre0");
        setLdr(11'h101, 4'hF, 32'h5A5A0002); applyStimulus(0, 1, "t3_pre1");
        setCpu(11'h100, 4'h0, 32'h0);
        setLdr(11'h101, 4'h0, 32'h0);
        for (int r = 0; r < 4; r++) applyStimulus(1, 1, "t3_rr");

        setCpu(11'h010, 4'h0, 32'h0);        applyStimulus(1, 0, "t4_pre");
        cpu_valid = 1'b1; cpu_addr = 11'h7FF; cpu_wstrb = 4'h0;
        @(negedge clk);
        chk("t4_issue_ce", ram_ce, 32'h1);
        reset = 1'b1;
        #1;
        chk("t4_rst_ctrl", {26'h0, ram_oce, ram_wre, ram_ce}, 32'h0);
        chk("t4_rst_ad", ram_ad, 32'h0);
        chk("t4_rst_din", ram_din, 32'h0);
        chk("t4_rst_rdy", {30'h0, ldr_ready, cpu_ready}, 32'h0);
        cpu_valid = 1'b0;
        rrNext = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_ready", {30'h0, ldr_ready, cpu_ready}, 32'h0);
        end
        setCpu(11'h100, 4'h0, 32'h0);
        setLdr(11'h101, 4'h0, 32'h0);
        applyStimulus(1, 1, "t4_first");

        for (int i = 0; i < 2048; i++) begin
            setLdr(i[10:0], 4'hF, $urandom);
            applyStimulus(0, 1, "t5_wr");
        end
        for (int i = 0; i < 2048; i++) begin
            setCpu(i[10:0], 4'h0, 32'h0);
            applyStimulus(1, 0, "t5_rd");
        end
        chk("t5_sb_drained", sbQ.size(), 32'h0);

`ifdef BOOTRAM_WP_EN
        wpLock = 1'b1;
        setCpu(11'h020, 4'hF, 32'h12345678); applyStimulus(1, 0, "t6_wr_blk");
        chk("t6_wp_err", wp_err, 32'h1);
        setCpu(11'h020, 4'h0, 32'h0);        applyStimulus(1, 0, "t6_rd_old");
        setLdr(11'h020, 4'hF, 32'hCAFEF00D); applyStimulus(0, 1, "t6_ldr_wr");
        setCpu(11'h020, 4'h0, 32'h0);        applyStimulus(1, 0, "t6_rd_new");
        chk("t6_wp_sticky", wp_err, 32'h1);
        wpLock = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
